// File: rtl/bus_pkg.sv
// Shared definitions for the 256-bit data bus: unit-select codes, sequencer states and
// the address decode check.
package bus_pkg;

    localparam logic [3:0] MainMemEn    = 4'd0;
    localparam logic [3:0] RegisterEn   = 4'd1;
    localparam logic [3:0] InstrMemEn   = 4'd2;
    localparam logic [3:0] MatrixAluEn  = 4'd3;
    localparam logic [3:0] IntegerAluEn = 4'd4;
    localparam logic [3:0] ExecuteEn    = 4'd5;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    // The register file is not mapped on this bus; codes above ExecuteEn are unassigned.
    function automatic logic unit_valid(input logic [15:0] addr);
        return (addr[15:12] != RegisterEn) && (addr[15:12] <= ExecuteEn);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_grant, wrapping.
module rr_arbiter #(
    parameter  int unsigned N    = 3,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [IdxW-1:0] i_last_grant,
    output logic [N-1:0]    o_grant,
    output logic [IdxW-1:0] o_grant_idx,
    output logic            o_valid
);

    logic [IdxW-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = IdxW'((32'(i_last_grant) + k) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant_idx    = w_idx;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin bus master arbiter and single-transaction sequencer for the shared data bus.
// Strobes are asserted only in WAIT, so the bus is idle for at least one cycle between grants.
module bus_master_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 1
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic [NUM_REQ-1:0]     ReqVec,
    input  logic [NUM_REQ*16-1:0]  ReqAddr,
    input  logic [NUM_REQ-1:0]     ReqnRead,
    input  logic [NUM_REQ*256-1:0] ReqWrData,
    output logic [NUM_REQ-1:0]     GrantVec,
    output logic [NUM_REQ-1:0]     DoneVec,
    output logic [NUM_REQ-1:0]     ErrVec,
    output logic [255:0]           RdDataOut,
    output logic [15:0]            BusAddress,
    output logic                   BusnRead,
    output logic                   BusnWrite,
    output logic [255:0]           BusDataOut,
    input  logic [255:0]           BusDataIn,
    output logic                   Busy
);

    localparam int unsigned IdxW   = $clog2(NUM_REQ);
    localparam int unsigned MaxLat = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;

    state_t               r_state;
    state_t               w_next_state;
    logic [IdxW-1:0]      r_last_grant;
    logic [NUM_REQ-1:0]   r_grant;
    logic [15:0]          r_addr;
    logic                 r_write;
    logic [255:0]         r_wdata;
    logic [CntW-1:0]      r_cnt;
    logic [255:0]         r_rdata;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IdxW-1:0]      w_gidx;
    logic [IdxW-1:0]      r_gidx;
    logic                 w_req_valid;
    logic                 w_err;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .i_req        (ReqVec),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_gidx),
        .o_valid      (w_req_valid)
    );

    assign w_err = !unit_valid(r_addr);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req_valid) w_next_state = ADDR;
            ADDR:    w_next_state = w_err ? DONE : WAIT;
            WAIT:    if (r_cnt == '0) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        Busy      = (r_state != IDLE);
        GrantVec  = (r_state != IDLE) ? r_grant : '0;
        DoneVec   = (r_state == DONE) ? r_grant : '0;
        ErrVec    = (r_state == DONE && w_err) ? r_grant : '0;
        BusnRead  = !(r_state == WAIT && !r_write);
        BusnWrite = !(r_state == WAIT && r_write);
    end

    assign BusAddress = r_addr;
    assign BusDataOut = r_wdata;
    assign RdDataOut  = r_rdata;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_last_grant <= IdxW'(NUM_REQ - 1);
            r_gidx       <= '0;
            r_grant      <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_valid) begin
                        r_gidx  <= w_gidx;
                        r_grant <= w_grant;
                        r_addr  <= ReqAddr[32'(w_gidx) * 16 +: 16];
                        r_write <= ReqnRead[w_gidx];
                        if (ReqnRead[w_gidx]) r_wdata <= ReqWrData[32'(w_gidx) * 256 +: 256];
                    end
                end
                ADDR: r_cnt <= r_write ? CntW'(WRITE_LAT - 1) : CntW'(READ_LAT - 1);
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_write) r_rdata <= BusDataIn;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE:    r_last_grant <= r_gidx;
                default: ;
            endcase
        end
    end

endmodule
